// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline boundary bundle: ID-side fields with their pipeline
// controls, plus the registered EX-side copies and the bubble counter.
// The master drives ID fields and observes EX; the pipeline register is the slave.
interface id_ex_reg_if #(
    parameter int W_DATA = 32,
    parameter int W_REG  = 4
);
    // Pipeline control
    logic              flush;
    logic              freeze;
    logic              id_valid;
    logic              cond_ok;

    // ID-stage instruction fields
    logic [W_DATA-1:0] id_pc;
    logic [W_DATA-1:0] id_val_rn;
    logic [W_DATA-1:0] id_val_rm;
    logic [11:0]       id_shift_operand;
    logic              id_imm;
    logic [23:0]       id_simm24;
    logic [W_REG-1:0]  id_dest;
    logic [W_REG-1:0]  id_src1;
    logic [W_REG-1:0]  id_src2;
    logic [3:0]        id_exe_cmd;
    logic              id_mem_r;
    logic              id_mem_w;
    logic              id_wb_en;
    logic              id_s;
    logic              id_b;
    logic              id_carry;

    // EX-stage registered copies
    logic [W_DATA-1:0] ex_pc;
    logic [W_DATA-1:0] ex_val_rn;
    logic [W_DATA-1:0] ex_val_rm;
    logic [11:0]       ex_shift_operand;
    logic              ex_imm;
    logic [23:0]       ex_simm24;
    logic [W_REG-1:0]  ex_dest;
    logic [W_REG-1:0]  ex_src1;
    logic [W_REG-1:0]  ex_src2;
    logic [3:0]        ex_exe_cmd;
    logic              ex_mem_r;
    logic              ex_mem_w;
    logic              ex_wb_en;
    logic              ex_s;
    logic              ex_b;
    logic              ex_carry;
    logic              ex_valid;
    logic [15:0]       bubble_cnt;

    modport master (
        output flush, freeze, id_valid, cond_ok,
        output id_pc, id_val_rn, id_val_rm, id_shift_operand, id_imm, id_simm24,
        output id_dest, id_src1, id_src2, id_exe_cmd,
        output id_mem_r, id_mem_w, id_wb_en, id_s, id_b, id_carry,
        input  ex_pc, ex_val_rn, ex_val_rm, ex_shift_operand, ex_imm, ex_simm24,
        input  ex_dest, ex_src1, ex_src2, ex_exe_cmd,
        input  ex_mem_r, ex_mem_w, ex_wb_en, ex_s, ex_b, ex_carry,
        input  ex_valid, bubble_cnt
    );

    modport slave (
        input  flush, freeze, id_valid, cond_ok,
        input  id_pc, id_val_rn, id_val_rm, id_shift_operand, id_imm, id_simm24,
        input  id_dest, id_src1, id_src2, id_exe_cmd,
        input  id_mem_r, id_mem_w, id_wb_en, id_s, id_b, id_carry,
        output ex_pc, ex_val_rn, ex_val_rm, ex_shift_operand, ex_imm, ex_simm24,
        output ex_dest, ex_src1, ex_src2, ex_exe_cmd,
        output ex_mem_r, ex_mem_w, ex_wb_en, ex_s, ex_b, ex_carry,
        output ex_valid, bubble_cnt
    );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register. Captures the decoded instruction at the end of
// ID and presents it to EX one cycle later. Condition-failed and non-valid
// instructions become bubbles; flush beats freeze, freeze beats a load.
// A saturating counter tracks bubbles caused by flushes and condition fails.
module id_ex_reg #(
    parameter int W_DATA = 32,
    parameter int W_REG  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_reg_if.slave   bus
);
    // Datapath state: don't-care while a bubble sits in EX
    logic [W_DATA-1:0] pc_q;
    logic [W_DATA-1:0] val_rn_q;
    logic [W_DATA-1:0] val_rm_q;
    logic [11:0]       shift_operand_q;
    logic              imm_q;
    logic [23:0]       simm24_q;
    logic [W_REG-1:0]  dest_q;
    logic [W_REG-1:0]  src1_q;
    logic [W_REG-1:0]  src2_q;
    logic              carry_q;

    // Control state: forced to zero for every bubble
    logic [3:0]        exe_cmd_q;
    logic              mem_r_q;
    logic              mem_w_q;
    logic              wb_en_q;
    logic              s_q;
    logic              b_q;
    logic              valid_q;

    logic [15:0]       bubble_cnt_q;

    logic              en;
    logic              capture;
    logic              count_bubble;

    // Decode the per-edge action: whether the register loads at all, whether
    // the ID instruction is accepted, and whether the load is a counted bubble
    always_comb begin
        en           = bus.id_valid & bus.cond_ok;
        capture      = bus.flush | ~bus.freeze;
        count_bubble = bus.flush | (~bus.freeze & bus.id_valid & ~bus.cond_ok);
    end

    // Datapath fields follow ID on every non-frozen edge, bubble or not,
    // so the waveform shows what was squashed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q            <= '0;
            val_rn_q        <= '0;
            val_rm_q        <= '0;
            shift_operand_q <= '0;
            imm_q           <= 1'b0;
            simm24_q        <= '0;
            dest_q          <= '0;
            src1_q          <= '0;
            src2_q          <= '0;
            carry_q         <= 1'b0;
        end else if (capture) begin
            pc_q            <= bus.id_pc;
            val_rn_q        <= bus.id_val_rn;
            val_rm_q        <= bus.id_val_rm;
            shift_operand_q <= bus.id_shift_operand;
            imm_q           <= bus.id_imm;
            simm24_q        <= bus.id_simm24;
            dest_q          <= bus.id_dest;
            src1_q          <= bus.id_src1;
            src2_q          <= bus.id_src2;
            carry_q         <= bus.id_carry;
        end
    end

    // Control fields: flush > freeze > accepted instruction > bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_cmd_q <= 4'd0;
            mem_r_q   <= 1'b0;
            mem_w_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            s_q       <= 1'b0;
            b_q       <= 1'b0;
            valid_q   <= 1'b0;
        end else if (bus.flush) begin
            exe_cmd_q <= 4'd0;
            mem_r_q   <= 1'b0;
            mem_w_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            s_q       <= 1'b0;
            b_q       <= 1'b0;
            valid_q   <= 1'b0;
        end else if (bus.freeze) begin
            exe_cmd_q <= exe_cmd_q;
            mem_r_q   <= mem_r_q;
            mem_w_q   <= mem_w_q;
            wb_en_q   <= wb_en_q;
            s_q       <= s_q;
            b_q       <= b_q;
            valid_q   <= valid_q;
        end else if (en) begin
            exe_cmd_q <= bus.id_exe_cmd;
            mem_r_q   <= bus.id_mem_r;
            mem_w_q   <= bus.id_mem_w;
            wb_en_q   <= bus.id_wb_en;
            s_q       <= bus.id_s;
            b_q       <= bus.id_b;
            valid_q   <= 1'b1;
        end else begin
            exe_cmd_q <= 4'd0;
            mem_r_q   <= 1'b0;
            mem_w_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            s_q       <= 1'b0;
            b_q       <= 1'b0;
            valid_q   <= 1'b0;
        end
    end

    // Count flush and condition-fail bubbles, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= 16'd0;
        end else if (count_bubble && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    assign bus.ex_pc            = pc_q;
    assign bus.ex_val_rn        = val_rn_q;
    assign bus.ex_val_rm        = val_rm_q;
    assign bus.ex_shift_operand = shift_operand_q;
    assign bus.ex_imm           = imm_q;
    assign bus.ex_simm24        = simm24_q;
    assign bus.ex_dest          = dest_q;
    assign bus.ex_src1          = src1_q;
    assign bus.ex_src2          = src2_q;
    assign bus.ex_carry         = carry_q;
    assign bus.ex_exe_cmd       = exe_cmd_q;
    assign bus.ex_mem_r         = mem_r_q;
    assign bus.ex_mem_w         = mem_w_q;
    assign bus.ex_wb_en         = wb_en_q;
    assign bus.ex_s             = s_q;
    assign bus.ex_b             = b_q;
    assign bus.ex_valid         = valid_q;
    assign bus.bubble_cnt       = bubble_cnt_q;

    // A bubble in EX must never carry an asserted control bit
    bubble_ctrl_quiet: assert property (
        @(posedge clk) disable iff (!rst_n)
        !valid_q |-> ({exe_cmd_q, mem_r_q, mem_w_q, wb_en_q, s_q, b_q} == '0)
    );
endmodule
